// File: rtl/ifetch_unit_if.sv
// Fetch-stage bundle: IMEM req/gnt/rvalid channel, redirect input and decode valid/ready output.
// master = fetch unit side, slave = memory/core environment side.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the fetch PC, issues IMEM reads, buffers {pc,instr} in an in-order FIFO.
// Latency: gnt N -> if_valid N+2 (N+1 with IFETCH_BYPASS_EN defined, same-cycle rdata bypass).
// Backpressure: requests stop when FIFO occupancy plus live in-flight reads reaches DEPTH.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = AW + 6;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          fifo_mem [DEPTH];
    logic [31:0]     fetch_pc;
    logic [31:0]     resp_pc;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   discard;
    logic [OW-1:0]   credit_used;
    logic [OW-1:0]   inflight_next;
    logic            fire;
    logic            resp_ok;
    logic            resp_drop;
    logic            resp_keep;
    logic            empty;
    logic            bypass;
    logic            push;
    logic            pop;
    logic            req;

    always_comb begin
        empty         = (count == '0);
        resp_ok       = bus.imem_rvalid && (outstanding != '0);
        resp_drop     = resp_ok && (discard != '0);
        resp_keep     = resp_ok && (discard == '0);
`ifdef IFETCH_BYPASS_EN
        bypass        = resp_keep && empty && bus.if_ready && !bus.redirect_valid;
`else
        bypass        = 1'b0;
`endif
        push          = resp_keep && !bypass;
        pop           = !empty && bus.if_ready;
        // Discarded reads are still counted in outstanding but will never occupy the FIFO.
        credit_used   = OW'(count) + outstanding - discard;
        req           = rst_n && !bus.redirect_valid && (credit_used < OW'(DEPTH));
        fire          = req && bus.imem_gnt;
        inflight_next = outstanding - OW'(resp_ok);
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;
    assign bus.if_valid  = !empty || bypass;
    assign bus.if_instr  = bypass ? bus.imem_rdata : fifo_mem[rd_ptr].instr;
    assign bus.if_pc     = bypass ? resp_pc       : fifo_mem[rd_ptr].pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            fetch_pc    <= bus.redirect_pc & ~32'd3;
            resp_pc     <= bus.redirect_pc & ~32'd3;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= inflight_next;
            // Every read still in flight after this edge is wrong-path. Pending discards are
            // already part of outstanding, so they are not added a second time.
            discard     <= inflight_next;
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + OW'(fire) - OW'(resp_ok);
            if (resp_drop) begin
                discard <= discard - OW'(1);
            end
            if (push) begin
                fifo_mem[wr_ptr] <= '{pc: resp_pc, instr: bus.imem_rdata};
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (push || bypass) begin
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: 1-cycle IMEM model (data = addr ^ KEY) with hold-off, scoreboard on decode side.
module tb_ifetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'h5A5A_0F0F;
`ifdef IFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic mem_hold = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [63:0] sb_q [$];
    logic [31:0] mem_q [$];
    logic [31:0] exp_pc = RESET_PC;
    logic [63:0] exp_word;

    always #5 clk = ~clk;

    ifetch_unit_if bus ();

    ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // IMEM response side: one queued word per cycle unless held off
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && !mem_hold && mem_q.size() > 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_q.pop_front() ^ KEY;
            end else begin
                bus.imem_rvalid = 1'b0;
            end
        end
    end

    // Scoreboard: grants push expected words, decode pops are compared
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            mem_q.delete();
            exp_pc = RESET_PC;
        end else if (bus.redirect_valid) begin
            total++;
            if (bus.imem_req !== 1'b0) begin
                bad++;
                $display("FAIL redirect_req: imem_req=%b want 0", bus.imem_req);
            end
            sb_q.delete();
            exp_pc = bus.redirect_pc & ~32'd3;
        end else begin
            if (bus.if_valid && bus.if_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: pc=%h instr=%h want no output", bus.if_pc, bus.if_instr);
                end else begin
                    exp_word = sb_q.pop_front();
                    if ({bus.if_pc, bus.if_instr} !== exp_word) begin
                        bad++;
                        $display("FAIL out_word: pc=%h instr=%h want pc=%h instr=%h",
                                 bus.if_pc, bus.if_instr, exp_word[63:32], exp_word[31:0]);
                    end
                end
            end
            if (bus.imem_req && bus.imem_gnt) begin
                total++;
                if (bus.imem_addr !== exp_pc) begin
                    bad++;
                    $display("FAIL fetch_addr: addr=%h want %h", bus.imem_addr, exp_pc);
                end
                mem_q.push_back(bus.imem_addr);
                sb_q.push_back({exp_pc, exp_pc ^ KEY});
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step();
        rst_n              = 1'b0;
        mem_hold           = 1'b0;
        bus.imem_gnt       = 1'b0;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain(output int left);
        step();
        bus.imem_gnt = 1'b0;
        bus.if_ready = 1'b1;
        mem_hold     = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        left = sb_q.size();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        total++;
        if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.if_valid); end
        total++;
        if (bus.if_instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", bus.if_instr); end
        total++;
        if (bus.if_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", bus.if_pc); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.imem_addr !== RESET_PC || bus.imem_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_release: addr=%h req=%b want %h 1", bus.imem_addr, bus.imem_req, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int first_g = -1;
        int first_v = -1;
        int pops = 0;
        int left;
        do_reset();
        bus.imem_gnt = 1'b1;
        bus.if_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (first_g < 0 && bus.imem_req && bus.imem_gnt) first_g = i;
            if (first_v < 0 && bus.if_valid) first_v = i;
            if (bus.if_valid && bus.if_ready) pops++;
        end
        total++;
        if (first_g != 0) begin bad++; $display("FAIL stream_first_gnt: cycle %0d want 0", first_g); end
        total++;
        if (first_v - first_g != LAT) begin
            bad++;
            $display("FAIL stream_latency: got %0d want %0d", first_v - first_g, LAT);
        end
        total++;
        if (pops < 36) begin bad++; $display("FAIL stream_rate: pops=%0d want >=36", pops); end
        drain(left);
        total++;
        if (left != 0) begin bad++; $display("FAIL stream_drain: left=%0d want 0", left); end
    endtask

    task automatic test_backpressure();
        int grants = 0;
        int pops = 0;
        int left;
        do_reset();
        bus.imem_gnt = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_gnt) grants++;
        end
        total++;
        if (grants != 4) begin bad++; $display("FAIL bp_grants: got %0d want 4", grants); end
        total++;
        if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL bp_req: got %b want 0", bus.imem_req); end
        total++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== RESET_PC) begin
            bad++;
            $display("FAIL bp_head: valid=%b pc=%h want 1 %h", bus.if_valid, bus.if_pc, RESET_PC);
        end
        step();
        bus.if_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.if_valid && bus.if_ready) pops++;
        end
        total++;
        if (pops < 25) begin bad++; $display("FAIL bp_resume: pops=%0d want >=25", pops); end
        drain(left);
        total++;
        if (left != 0) begin bad++; $display("FAIL bp_drain: left=%0d want 0", left); end
    endtask

    task automatic test_gnt_stall();
        int left;
        do_reset();
        bus.imem_gnt = 1'b1;
        bus.if_ready = 1'b1;
        repeat (5) @(negedge clk);
        step();
        bus.imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd20) begin
                bad++;
                $display("FAIL stall_hold: req=%b addr=%h want 1 00000014", bus.imem_req, bus.imem_addr);
            end
        end
        step();
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        @(negedge clk);
        total++;
        if (bus.imem_addr !== 32'd24) begin bad++; $display("FAIL stall_advance: addr=%h want 00000018", bus.imem_addr); end
        drain(left);
        total++;
        if (left != 0) begin bad++; $display("FAIL stall_drain: left=%0d want 0", left); end
    endtask

    task automatic test_redirect();
        bit seen = 0;
        int left;
        do_reset();
        bus.imem_gnt = 1'b1;
        step();
        mem_hold = 1'b1;
        step();
        step();
        bus.imem_gnt       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        total++;
        if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL redir_pre: valid=%b want 1", bus.if_valid); end
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h100) begin
            bad++;
            $display("FAIL redir_flush: valid=%b addr=%h want 0 00000100", bus.if_valid, bus.imem_addr);
        end
        step();
        mem_hold     = 1'b0;
        bus.imem_gnt = 1'b1;
        bus.if_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!seen && bus.if_valid) begin
                seen = 1;
                total++;
                if (bus.if_pc !== 32'h100 || bus.if_instr !== (32'h100 ^ KEY)) begin
                    bad++;
                    $display("FAIL redir_first: pc=%h instr=%h want 00000100 %h", bus.if_pc, bus.if_instr, 32'h100 ^ KEY);
                end
            end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL redir_timeout: no if_valid within 20 cycles, want one"); end
        drain(left);
        total++;
        if (left != 0) begin bad++; $display("FAIL redir_drain: left=%0d want 0", left); end
    endtask

    task automatic test_redirect_collide();
        bit seen = 0;
        int left;
        do_reset();
        bus.imem_gnt = 1'b1;
        bus.if_ready = 1'b1;
        repeat (6) @(negedge clk);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        total++;
        if (bus.imem_rvalid !== 1'b1) begin bad++; $display("FAIL collide_rvalid: got %b want 1", bus.imem_rvalid); end
`ifndef IFETCH_BYPASS_EN
        total++;
        if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL collide_pop: valid=%b want 1", bus.if_valid); end
`endif
        step();
        bus.redirect_pc = 32'h0000_0302;
        step();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!seen && bus.if_valid) begin
                seen = 1;
                total++;
                if (bus.if_pc !== 32'h300) begin bad++; $display("FAIL collide_first: pc=%h want 00000300", bus.if_pc); end
            end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL collide_timeout: no if_valid within 20 cycles, want one"); end
        drain(left);
        total++;
        if (left != 0) begin bad++; $display("FAIL collide_drain: left=%0d want 0", left); end
    endtask

    task automatic test_back_to_back();
        bit seen = 0;
        int left;
        do_reset();
        bus.imem_gnt = 1'b1;
        mem_hold     = 1'b1;
        step();
        step();
        step();
        bus.imem_gnt       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0300;
        mem_hold           = 1'b0;
        step();
        bus.redirect_pc = 32'h0000_0400;
        @(negedge clk);
        total++;
        if (bus.imem_rvalid !== 1'b1) begin bad++; $display("FAIL b2b_rvalid: got %b want 1", bus.imem_rvalid); end
        step();
        bus.redirect_valid = 1'b0;
        bus.imem_gnt       = 1'b1;
        bus.if_ready       = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!seen && bus.if_valid) begin
                seen = 1;
                total++;
                if (bus.if_pc !== 32'h400 || bus.if_instr !== (32'h400 ^ KEY)) begin
                    bad++;
                    $display("FAIL b2b_first: pc=%h instr=%h want 00000400 %h", bus.if_pc, bus.if_instr, 32'h400 ^ KEY);
                end
            end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL b2b_timeout: no if_valid within 20 cycles, want one"); end
        drain(left);
        total++;
        if (left != 0) begin bad++; $display("FAIL b2b_drain: left=%0d want 0", left); end
    endtask

    task automatic test_reset_mid();
        int left;
        do_reset();
        bus.imem_gnt = 1'b1;
        step();
        mem_hold = 1'b1;
        step();
        step();
        step();
        bus.imem_gnt = 1'b0;
        @(negedge clk);
        total++;
        if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre: valid=%b want 1", bus.if_valid); end
        step();
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async: valid=%b req=%b want 0 0", bus.if_valid, bus.imem_req);
        end
        step();
        rst_n    = 1'b1;
        mem_hold = 1'b0;
        @(negedge clk);
        total++;
        if (bus.imem_addr !== RESET_PC) begin bad++; $display("FAIL midrst_addr: addr=%h want %h", bus.imem_addr, RESET_PC); end
        step();
        bus.imem_gnt = 1'b1;
        bus.if_ready = 1'b1;
        repeat (10) @(negedge clk);
        drain(left);
        total++;
        if (left != 0) begin bad++; $display("FAIL midrst_drain: left=%0d want 0", left); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_gnt       = 1'b0;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect();
        test_redirect_collide();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
